// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: depth-generic scoreboard of in-flight writers deciding issue/stall and per-port forward select.
// Optional operand forwarding is enabled by defining HAZARD_FORWARDING_EN.
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int DEPTH       = 3,
    parameter int NUM_READ    = 3,
    parameter int FLUSH_SLOTS = 1,
    parameter int FWD_W       = 4
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           iIssueValid,
    input  logic [NUM_READ*REG_ADDR_W-1:0] iReadAddr,
    input  logic [NUM_READ-1:0]            iReadUsed,
    input  logic                           iWriteEn,
    input  logic [REG_ADDR_W-1:0]          iWriteAddr,
    input  logic                           iIsLoad,
    input  logic                           iFlush,
    output logic                           oStall,
    output logic                           oIssue,
    output logic [NUM_READ*FWD_W-1:0]      oFwdSel,
    output logic [3:0]                     oInFlight,
    output logic [15:0]                    oStallCycles
);
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    logic [DEPTH-1:0]      slot_valid;
    logic [DEPTH-1:0]      slot_load;
    logic [REG_ADDR_W-1:0] slot_addr [DEPTH];
    logic [NUM_READ-1:0]   port_stall;
    // Scan oldest to youngest so the youngest matching slot has the last word.
    always_comb begin
        port_stall = '0;
        oFwdSel = '0;
        for (int k = 0; k < NUM_READ; k++)
            for (int i = DEPTH - 1; i >= 0; i--)
                if (iIssueValid && iReadUsed[k] && |iReadAddr[k*REG_ADDR_W +: REG_ADDR_W] &&
                    slot_valid[i] && slot_addr[i] == iReadAddr[k*REG_ADDR_W +: REG_ADDR_W]) begin
                    port_stall[k] = !FWD_EN || (i == 0 && slot_load[i]);
                    oFwdSel[k*FWD_W +: FWD_W] = port_stall[k] ? FWD_W'(0) : FWD_W'(i + 1);
                end
    end
    assign oStall = |port_stall && !iFlush;
    assign oIssue = iIssueValid && !oStall && !iFlush;
    always_comb begin
        oInFlight = '0;
        for (int i = 0; i < DEPTH; i++)
            oInFlight = oInFlight + 4'(slot_valid[i]);
    end
    // A flush kills the youngest pre-edge slots, so slot i is cleared when its source i-1 is among them.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            slot_valid <= '0;
            slot_load <= '0;
            for (int i = 0; i < DEPTH; i++)
                slot_addr[i] <= '0;
            oStallCycles <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slot_valid[i] <= slot_valid[i-1] && !(iFlush && i <= FLUSH_SLOTS);
                slot_addr[i] <= slot_addr[i-1];
                slot_load[i] <= slot_load[i-1];
            end
            slot_valid[0] <= oIssue && iWriteEn && |iWriteAddr;
            slot_addr[0] <= iWriteAddr;
            slot_load[0] <= iIsLoad;
            if (oStall && ~&oStallCycles)
                oStallCycles <= oStallCycles + 16'd1;
        end
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard-detection and forwarding-select unit for the in-order integer pipeline.
- It replaces the fixed three-destination compare in the current bubble logic with a depth-generic scoreboard of in-flight writers.
- It sits between decode and register-file read. Each cycle it decides whether the decoded instruction may issue, and which in-flight stage each source operand is taken from.
- It also tracks flush and load-use, and keeps a stall statistic counter.

Parameters:
- REG_ADDR_W, 5: register address width; register 0 is hardwired zero and never hazards.
- DEPTH, 3: number of tracked post-issue stages (slot 0 = stage after issue, slot DEPTH-1 = last before write-back commit); legal range 1..8.
- NUM_READ, 3: number of source-operand read ports checked per instruction.
- FLUSH_SLOTS, 1: number of youngest slots invalidated by iFlush; legal range 0..DEPTH.
- FWD_W, 4: forwarding-select width per read port; must hold the value DEPTH.

Ports:
- Clock  in  1  pipeline clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- iIssueValid  in  1  decoded instruction present.
- iReadAddr  in  NUM_READ*REG_ADDR_W  source addresses; port k occupies bits [k*REG_ADDR_W +: REG_ADDR_W].
- iReadUsed  in  NUM_READ  per-port "operand actually read" qualifier.
- iWriteEn  in  1  instruction writes a register.
- iWriteAddr  in  REG_ADDR_W  destination register.
- iIsLoad  in  1  destination value is available only from the memory stage.
- iFlush  in  1  branch taken; kill the youngest FLUSH_SLOTS slots and the issuing instruction.
- oStall  out  1  hold fetch/decode this cycle (combinational).
- oIssue  out  1  instruction accepted this cycle (combinational).
- oFwdSel  out  NUM_READ*FWD_W  per-port source select: 0 = register file, k = slot k-1.
- oInFlight  out  4  count of valid writing slots.
- oStallCycles  out  16  saturating count of stalled cycles.

Behaviour:
- Reset (async, Reset=1): all slots invalid, oInFlight=0, oStallCycles=0; with no input hazard, oStall=0, oIssue=iIssueValid, oFwdSel=0.
- Slot contents: {valid, addr, is_load}. On each edge slot[i] <= slot[i-1] for i≥1, and slot DEPTH-1 retires.
- slot[0] <= {1, iWriteAddr, iIsLoad} when oIssue && iWriteEn && iWriteAddr!=0; otherwise slot[0] is a bubble.
- Match(k,i): iIssueValid && iReadUsed[k] && addr_k!=0 && slot[i].valid && slot[i].addr==addr_k. The youngest (lowest i) match wins.
- Without forwarding, oStall = OR of all Match(k,i), and oFwdSel = 0.
- oIssue = iIssueValid && !oStall && !iFlush.
- iFlush: at the edge, slots 0..FLUSH_SLOTS-1 become invalid after the shift, slot[0] is a bubble, and older slots shift normally. iFlush overrides oStall; oStall is forced 0 while iFlush=1.
- Simultaneous issue and retire of the same address: the compare uses pre-edge slot state, so the retiring slot still hazards in that cycle.
- oInFlight updates one cycle after issue/retire and reflects registered slot state only.
- oStallCycles increments on every edge where oStall=1, saturating at 16'hFFFF; only Reset clears it.
- Latency: hazard decision is zero-cycle (combinational on the current inputs and registered slots). A stall lasts until the matching slot retires.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- When defined:
  - A match in slot i with is_load=0 does not stall and sets oFwdSel[k]=i+1.
  - A match in slot 0 with is_load=1 stalls (load-use). Once that load reaches slot 1 or later, it forwards with oFwdSel=i+1.
  - Priority is always the youngest match.
- When undefined: every match stalls, and oFwdSel is tied to 0.

Test Plan (DEPTH=3, NUM_READ=3, FLUSH_SLOTS=1):
- Reset asserted mid-stall with slots holding r5 -> immediately oInFlight=0, oStall=0, oStallCycles=0. This holds without waiting for a clock edge.
- Cycle0 write r5 issued, cycle1 read port0=r5 used, forwarding off -> oStall=1 in cycles 1,2,3; oIssue=1 in cycle4; oStallCycles=3.
- Same stimulus with HAZARD_FORWARDING_EN -> cycle1 oStall=0, oFwdSel[port0]=1. If the read instead occurs in cycle2, oFwdSel=2.
- Cycle0 load r7, cycle1 read r7, forwarding on -> cycle1 oStall=1; cycle2 oStall=0 with oFwdSel=2.
- Write r0 then read r0 on all ports; also read r5 with iReadUsed=0 after a write to r5 -> no stall, oFwdSel=0, oInFlight stays 0 for r0.
- Write r9 issued, next cycle iFlush=1 with read r9 pending -> oStall=0, oIssue=0. The r9 slot is invalidated, so the following cycle a read of r9 issues with oFwdSel=0.
- Force 70000 consecutive stalled cycles -> oStallCycles holds 16'hFFFF.
